pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined LC-3b CPU.
- Sits between the two cache controllers and the physical memory / L2 port.
- Grants one requester at a time with round-robin priority. Latches the winning command so that memory-side signals stay stable.
- Routes the response and read data back to the granted cache only. Keeps saturating grant counters for performance checks.

Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word).
- LINE_WIDTH, 128, cache line width in bits.
- CNT_WIDTH, 16, width of each grant counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- icache_pmem_read  in  1  I-cache line fill request; held until icache_pmem_resp.
- icache_pmem_address  in  ADDR_WIDTH  I-cache line address.
- icache_pmem_rdata  out  LINE_WIDTH  fill data to I-cache.
- icache_pmem_resp  out  1  completion pulse to I-cache.
- dcache_pmem_read  in  1  D-cache line fill request; held until dcache_pmem_resp.
- dcache_pmem_write  in  1  D-cache writeback request; held until dcache_pmem_resp.
- dcache_pmem_address  in  ADDR_WIDTH  D-cache line address.
- dcache_pmem_wdata  in  LINE_WIDTH  writeback data.
- dcache_pmem_rdata  out  LINE_WIDTH  fill data to D-cache.
- dcache_pmem_resp  out  1  completion pulse to D-cache.
- pmem_read  out  1  memory read strobe (registered).
- pmem_write  out  1  memory write strobe (registered).
- pmem_address  out  ADDR_WIDTH  latched address (registered).
- pmem_wdata  out  LINE_WIDTH  latched write data (registered).
- pmem_rdata  in  LINE_WIDTH  memory read data.
- pmem_resp  in  1  memory completion; valid for one cycle.
- icache_grants  out  CNT_WIDTH  saturating count of I-cache grants.
- dcache_grants  out  CNT_WIDTH  saturating count of D-cache grants.

Behaviour:
- States:
  - IDLE: no transaction outstanding.
  - SERVE_I: I-cache transaction outstanding.
  - SERVE_D: D-cache transaction outstanding.
- Reset (async, immediate), including mid-transaction:
  - state=IDLE, last_grant=I (so D wins the first tie).
  - pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, both counters=0.
  - The in-flight transaction is abandoned; a pmem_resp arriving after reset is ignored.
- Request decoding:
  - ireq = icache_pmem_read.
  - dreq = dcache_pmem_read | dcache_pmem_write.
- IDLE transitions:
  - Only ireq: go to SERVE_I.
  - Only dreq: go to SERVE_D.
  - Both: grant the side not equal to last_grant.
  - Neither: stay in IDLE.
- On a grant edge:
  - Latch pmem_address from the winner.
  - For D: latch pmem_wdata from dcache_pmem_wdata, pmem_write=dcache_pmem_write, pmem_read=dcache_pmem_read & ~dcache_pmem_write. If read and write are both asserted (illegal), the write wins.
  - For I: pmem_read=1, pmem_write=0, pmem_wdata holds its previous value.
  - Update last_grant.
  - Increment the winner's counter, saturating at all-ones.
- Latency: request first seen in IDLE at cycle N; memory strobes asserted at N+1.
- SERVE_x:
  - Strobes, address and wdata are held constant regardless of requester inputs.
  - While pmem_resp=1, <x>_pmem_resp=pmem_resp (combinational, same cycle). The other cache's resp stays 0.
  - Both rdata outputs = pmem_rdata (combinational pass-through). Caches must qualify rdata with their own resp.
  - On the pmem_resp edge: clear pmem_read/pmem_write and go to IDLE.
- Turnaround:
  - A pending request is sampled in the IDLE cycle after resp, giving one bubble cycle. This lets the requester drop its held request before it could be re-granted.
  - Back-to-back same-side requests therefore see strobes two cycles after the previous resp.
- pmem_resp in IDLE (spurious): ignored; no cache resp asserted.
- Requester deasserts mid-service (protocol violation): the transaction runs to completion and resp is still pulsed to that cache.
- Round-robin bound: with both sides continuously requesting, grants alternate I/D strictly. Neither side waits more than one foreign transaction.

Test Plan:
- Reset, then icache_pmem_read=1 at address 0x1230; memory responds 3 cycles after strobe with rdata=128'hA5… -> pmem_read=1, pmem_address=0x1230 one cycle after the request; icache_pmem_resp=1 with the data the same cycle as pmem_resp; icache_grants=1; dcache_pmem_resp stays 0.
- Both caches request in the same cycle after reset (I read 0x0040, D write 0x8000 with wdata=128'hDEAD…) -> D is granted first (pmem_write=1, address 0x8000, wdata latched); I is granted on the second cycle after D's resp.
- Both sides held requesting for 6 transactions -> grant order D,I,D,I,D,I; each counter=3.
- Assert reset while SERVE_D is mid-transaction, then pulse pmem_resp -> strobes drop immediately, state=IDLE, counters=0, no dcache_pmem_resp.
- Pulse pmem_resp while IDLE; then D asserts read and write together at 0x0100 -> no resp to either cache; transaction issued as a write (pmem_write=1, pmem_read=0).
- Preload icache_grants near all-ones by issuing 65537 I requests (or reduce CNT_WIDTH to 2 with 5 requests) -> counter saturates at all-ones without wrapping.

Source files
------------

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//
// Shares one physical-memory line port between the I-cache miss path and the
// D-cache miss/writeback path. One requester is served at a time. When both
// request together, the side that was not granted last wins (round robin). The
// winning command is latched so the memory-side signals stay stable for the
// whole transaction. The completion pulse is routed only to the granted cache.
// Read data is passed straight through to both caches.
//
// Handshake: a cache raises its read/write request and holds it until its
// *_pmem_resp pulse. Memory sees registered strobes that stay high until the
// single-cycle pmem_resp. Each side has a saturating grant counter.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   icache_pmem_read/address       I-cache fill request and line address
//   icache_pmem_rdata/resp         fill data and completion pulse to I-cache
//   dcache_pmem_read/write         D-cache fill / writeback request
//   dcache_pmem_address/wdata      D-cache line address and writeback data
//   dcache_pmem_rdata/resp         fill data and completion pulse to D-cache
//   pmem_read/write/address/wdata  registered command to memory
//   pmem_rdata/resp                memory read data and completion pulse
//   icache_grants, dcache_grants   saturating grant counters
//   o_dbg_state                    FSM state: 0 IDLE, 1 SERVE_I, 2 SERVE_D
// -----------------------------------------------------------------------------
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,
    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [CNT_WIDTH-1:0]  icache_grants,
    output logic [CNT_WIDTH-1:0]  dcache_grants,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last_d;      // 1 when the most recent grant went to D
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic [ADDR_WIDTH-1:0] r_pmem_address;
    logic [LINE_WIDTH-1:0] r_pmem_wdata;
    logic [CNT_WIDTH-1:0]  r_icache_grants;
    logic [CNT_WIDTH-1:0]  r_dcache_grants;

    logic w_ireq;
    logic w_dreq;
    logic w_grant_i;
    logic w_grant_d;
    logic w_done;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decode.
    always_comb begin
        w_ireq       = icache_pmem_read;
        w_dreq       = dcache_pmem_read | dcache_pmem_write;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done       = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                // On a tie D wins unless D was the last side granted.
                w_grant_d = w_dreq & (~w_ireq | ~r_last_d);
                w_grant_i = w_ireq & ~w_grant_d;
                if (w_grant_i) begin
                    w_next_state = SERVE_I;
                end else if (w_grant_d) begin
                    w_next_state = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                // Always return through IDLE: the bubble cycle lets the served
                // cache drop its held request before it can be re-granted.
                if (pmem_resp) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latched memory command, round-robin pointer and grant counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_d        <= 1'b0;
            r_pmem_read     <= 1'b0;
            r_pmem_write    <= 1'b0;
            r_pmem_address  <= '0;
            r_pmem_wdata    <= '0;
            r_icache_grants <= '0;
            r_dcache_grants <= '0;
        end else if (w_grant_d) begin
            r_last_d       <= 1'b1;
            r_pmem_address <= dcache_pmem_address;
            r_pmem_wdata   <= dcache_pmem_wdata;
            // Read and write together is illegal; treat it as a writeback.
            r_pmem_write   <= dcache_pmem_write;
            r_pmem_read    <= dcache_pmem_read & ~dcache_pmem_write;
            if (r_dcache_grants != {CNT_WIDTH{1'b1}}) begin
                r_dcache_grants <= r_dcache_grants + 1'b1;
            end
        end else if (w_grant_i) begin
            r_last_d       <= 1'b0;
            r_pmem_address <= icache_pmem_address;
            r_pmem_read    <= 1'b1;
            r_pmem_write   <= 1'b0;
            if (r_icache_grants != {CNT_WIDTH{1'b1}}) begin
                r_icache_grants <= r_icache_grants + 1'b1;
            end
        end else if (w_done) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end
    end

    // Response routing; a pmem_resp seen while IDLE reaches neither cache.
    assign icache_pmem_resp  = (r_state == SERVE_I) & pmem_resp;
    assign dcache_pmem_resp  = (r_state == SERVE_D) & pmem_resp;
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

    assign pmem_read     = r_pmem_read;
    assign pmem_write    = r_pmem_write;
    assign pmem_address  = r_pmem_address;
    assign pmem_wdata    = r_pmem_wdata;
    assign icache_grants = r_icache_grants;
    assign dcache_grants = r_dcache_grants;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//
// Directed and randomized checks of pmem_arbiter. The bench acts as both
// caches and as memory. A small reference model tracks which side should win
// each grant, what command memory should see, and the saturating grant
// counts. Counters are built 3 bits wide so saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;

    localparam int AW      = 16;
    localparam int LW      = 128;
    localparam int CW      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_I    = 2'd1;
    localparam logic [1:0] ST_D    = 2'd2;

    logic          clk;
    logic          reset;
    logic          icache_pmem_read;
    logic [AW-1:0] icache_pmem_address;
    logic [LW-1:0] icache_pmem_rdata;
    logic          icache_pmem_resp;
    logic          dcache_pmem_read;
    logic          dcache_pmem_write;
    logic [AW-1:0] dcache_pmem_address;
    logic [LW-1:0] dcache_pmem_wdata;
    logic [LW-1:0] dcache_pmem_rdata;
    logic          dcache_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic [CW-1:0] icache_grants;
    logic [CW-1:0] dcache_grants;
    logic [1:0]    o_dbg_state;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit            m_last_d;
    int            m_cnt_i;
    int            m_cnt_d;
    logic [LW-1:0] m_wdata;
    int            wait_n;

    pmem_arbiter #(
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .icache_pmem_read   (icache_pmem_read),
        .icache_pmem_address(icache_pmem_address),
        .icache_pmem_rdata  (icache_pmem_rdata),
        .icache_pmem_resp   (icache_pmem_resp),
        .dcache_pmem_read   (dcache_pmem_read),
        .dcache_pmem_write  (dcache_pmem_write),
        .dcache_pmem_address(dcache_pmem_address),
        .dcache_pmem_wdata  (dcache_pmem_wdata),
        .dcache_pmem_rdata  (dcache_pmem_rdata),
        .dcache_pmem_resp   (dcache_pmem_resp),
        .pmem_read          (pmem_read),
        .pmem_write         (pmem_write),
        .pmem_address       (pmem_address),
        .pmem_wdata         (pmem_wdata),
        .pmem_rdata         (pmem_rdata),
        .pmem_resp          (pmem_resp),
        .icache_grants      (icache_grants),
        .dcache_grants      (dcache_grants),
        .o_dbg_state        (o_dbg_state)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : CNT_MAX;
    endfunction

    // Reset driver; returns on a falling edge with the DUT idle.
    task automatic apply_reset();
        reset               = 1'b1;
        icache_pmem_read    = 1'b0;
        icache_pmem_address = '0;
        dcache_pmem_read    = 1'b0;
        dcache_pmem_write   = 1'b0;
        dcache_pmem_address = '0;
        dcache_pmem_wdata   = '0;
        pmem_resp           = 1'b0;
        pmem_rdata          = rand_line();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_last_d = 1'b0;
        m_cnt_i  = 0;
        m_cnt_d  = 0;
        m_wdata  = '0;
        @(negedge clk);
        chk("rst_state", o_dbg_state, ST_IDLE);
        chk("rst_read", pmem_read, 0);
        chk("rst_write", pmem_write, 0);
        chk("rst_addr", pmem_address, 0);
        chk("rst_wdata", pmem_wdata, 0);
        chk("rst_icnt", icache_grants, 0);
        chk("rst_dcnt", dcache_grants, 0);
    endtask

    // Memory driver for one transaction. Call on a falling edge with the
    // requests already set; the model picks the expected winner. Memory
    // answers lat cycles after the strobe. Winner drops its request after resp.
    task automatic run_txn(input int lat, input logic [LW-1:0] rd, output int n);
        bit            ir, dq, win_d, e_rd, e_wr;
        logic [AW-1:0] e_addr;
        ir    = icache_pmem_read;
        dq    = dcache_pmem_read | dcache_pmem_write;
        win_d = dq && (!ir || !m_last_d);
        if (win_d) begin
            e_addr  = dcache_pmem_address;
            e_wr    = dcache_pmem_write;
            e_rd    = dcache_pmem_read & ~dcache_pmem_write;
            m_wdata = dcache_pmem_wdata;
            m_cnt_d = sat_inc(m_cnt_d);
        end else begin
            e_addr  = icache_pmem_address;
            e_wr    = 1'b0;
            e_rd    = 1'b1;
            m_cnt_i = sat_inc(m_cnt_i);
        end
        m_last_d = win_d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pmem_read | pmem_write) && n < 8);
        chk("grant_latency", n, 1);
        chk("grant_state", o_dbg_state, win_d ? ST_D : ST_I);
        chk("grant_addr", pmem_address, e_addr);
        chk("grant_read", pmem_read, e_rd);
        chk("grant_write", pmem_write, e_wr);
        chk("grant_wdata", pmem_wdata, m_wdata);
        chk("grant_icnt", icache_grants, m_cnt_i);
        chk("grant_dcnt", dcache_grants, m_cnt_d);
        for (int k = 0; k < lat; k++) begin
            @(posedge clk);
            #1;
            // Disturb the winner's inputs; the latched command must not move.
            if (win_d) begin
                dcache_pmem_address = AW'($urandom());
                dcache_pmem_wdata   = rand_line();
            end else begin
                icache_pmem_address = AW'($urandom());
            end
            @(negedge clk);
            chk("hold_addr", pmem_address, e_addr);
            chk("hold_read", pmem_read, e_rd);
            chk("hold_write", pmem_write, e_wr);
            chk("hold_wdata", pmem_wdata, m_wdata);
            chk("hold_iresp", icache_pmem_resp, 0);
            chk("hold_dresp", dcache_pmem_resp, 0);
        end
        @(posedge clk);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
        @(negedge clk);
        chk("resp_i", icache_pmem_resp, !win_d);
        chk("resp_d", dcache_pmem_resp, win_d);
        chk("rdata_i", icache_pmem_rdata, rd);
        chk("rdata_d", dcache_pmem_rdata, rd);
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        if (win_d) begin
            dcache_pmem_read  = 1'b0;
            dcache_pmem_write = 1'b0;
        end else begin
            icache_pmem_read = 1'b0;
        end
        @(negedge clk);
        chk("done_read", pmem_read, 0);
        chk("done_write", pmem_write, 0);
        chk("done_state", o_dbg_state, ST_IDLE);
    endtask

    initial begin
        int mode;

        // 1: single I-cache fill.
        apply_reset();
        @(posedge clk);
        #1;
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 16'h1230;
        @(negedge clk);
        chk("t1_no_strobe_yet", pmem_read, 0);
        run_txn(3, {4{32'hA5A5A5A5}}, wait_n);
        chk("t1_icnt", icache_grants, 1);
        chk("t1_dcnt", dcache_grants, 0);

        // 2: simultaneous requests after reset, D first, I after the bubble.
        apply_reset();
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 16'h0040;
        dcache_pmem_write   = 1'b1;
        dcache_pmem_address = 16'h8000;
        dcache_pmem_wdata   = {4{32'hDEADBEEF}};
        run_txn(2, rand_line(), wait_n);
        chk("t2_d_first", dcache_grants, 1);
        chk("t2_i_waits", icache_grants, 0);
        run_txn(1, rand_line(), wait_n);
        chk("t2_i_second", icache_grants, 1);

        // 3: both sides keep requesting: strict D,I,D,I,D,I.
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            if (!icache_pmem_read) begin
                icache_pmem_read    = 1'b1;
                icache_pmem_address = AW'($urandom());
            end
            if (!dcache_pmem_read) begin
                dcache_pmem_read    = 1'b1;
                dcache_pmem_address = AW'($urandom());
            end
            run_txn($urandom_range(0, 3), rand_line(), wait_n);
            chk("t3_dcnt", dcache_grants, k / 2 + 1);
            chk("t3_icnt", icache_grants, (k + 1) / 2);
        end
        icache_pmem_read = 1'b0;
        dcache_pmem_read = 1'b0;
        chk("t3_final_i", icache_grants, 3);
        chk("t3_final_d", dcache_grants, 3);

        // 4: reset in the middle of a D transaction.
        apply_reset();
        dcache_pmem_read    = 1'b1;
        dcache_pmem_address = 16'h2222;
        dcache_pmem_wdata   = rand_line();
        @(negedge clk);
        chk("t4_served", o_dbg_state, ST_D);
        chk("t4_strobe", pmem_read, 1);
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_read", pmem_read, 0);
        chk("t4_rst_state", o_dbg_state, ST_IDLE);
        chk("t4_rst_dcnt", dcache_grants, 0);
        chk("t4_rst_addr", pmem_address, 0);
        dcache_pmem_read = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        m_last_d = 1'b0;
        m_cnt_i  = 0;
        m_cnt_d  = 0;
        m_wdata  = '0;
        @(posedge clk);
        #1 pmem_resp = 1'b1;
        @(negedge clk);
        chk("t4_late_dresp", dcache_pmem_resp, 0);
        chk("t4_late_iresp", icache_pmem_resp, 0);
        chk("t4_late_state", o_dbg_state, ST_IDLE);
        @(posedge clk);
        #1 pmem_resp = 1'b0;

        // 5: spurious resp while idle, then illegal read+write from D.
        @(posedge clk);
        #1 pmem_resp = 1'b1;
        @(negedge clk);
        chk("t5_spur_iresp", icache_pmem_resp, 0);
        chk("t5_spur_dresp", dcache_pmem_resp, 0);
        chk("t5_spur_read", pmem_read, 0);
        @(posedge clk);
        #1 pmem_resp = 1'b0;
        @(negedge clk);
        dcache_pmem_read    = 1'b1;
        dcache_pmem_write   = 1'b1;
        dcache_pmem_address = 16'h0100;
        dcache_pmem_wdata   = rand_line();
        run_txn(1, rand_line(), wait_n);

        // 6: I counter saturates at all-ones.
        apply_reset();
        for (int k = 0; k < CNT_MAX + 2; k++) begin
            icache_pmem_read    = 1'b1;
            icache_pmem_address = AW'($urandom());
            run_txn(0, rand_line(), wait_n);
        end
        chk("t6_sat_i", icache_grants, CNT_MAX);
        chk("t6_sat_d", dcache_grants, 0);

        // 7: random request mixes against the model.
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            if (!icache_pmem_read && $urandom_range(0, 1) == 1) begin
                icache_pmem_read    = 1'b1;
                icache_pmem_address = AW'($urandom());
            end
            if (!(dcache_pmem_read | dcache_pmem_write) && $urandom_range(0, 1) == 1) begin
                mode                = $urandom_range(0, 2);
                dcache_pmem_read    = (mode != 1);
                dcache_pmem_write   = (mode != 0);
                dcache_pmem_address = AW'($urandom());
                dcache_pmem_wdata   = rand_line();
            end
            if (!icache_pmem_read && !(dcache_pmem_read | dcache_pmem_write)) begin
                icache_pmem_read    = 1'b1;
                icache_pmem_address = AW'($urandom());
            end
            run_txn($urandom_range(0, 4), rand_line(), wait_n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
